// File: rtl/readout_seq.sv
// readout_seq: walks byte addresses 0..NUM_BYTES-1 through an external select
// decoder and streams each byte out over a valid/ready handshake.
// Ports: clk/rst_n (async active-low), start/abort frame control,
// addr -> decoder, rd_data <- decoder, out_data/out_valid/out_ready stream
// with out_first/out_last framing, busy/done/aborted frame status.
module readout_seq #(
  parameter int NUM_BYTES = 24,
  parameter int SETTLE    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic [4:0] addr,
  input  logic [7:0] rd_data,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_first,
  output logic       out_last,
  output logic       busy,
  output logic       done,
  output logic       aborted
);
  typedef enum logic [2:0] {IDLE, SETTLE_W, CAPTURE, SEND, FINISH} state_t;
  localparam logic [4:0] LAST_ADDR = 5'(NUM_BYTES - 1);
  localparam logic [4:0] IDLE_ADDR = 5'd31;
  state_t     state, state_nx;
  logic [3:0] cnt;
  logic       hs, last_byte, settle_end, in_frame;
  assign hs         = out_valid & out_ready;
  assign last_byte  = addr == LAST_ADDR;
  assign settle_end = cnt == 4'(SETTLE - 1);
  // FINISH is excluded: a frame already wrapping up cannot be aborted again
  assign in_frame   = state == SETTLE_W || state == CAPTURE || state == SEND;
  assign busy       = state != IDLE;
  assign done       = state == FINISH;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = start ? SETTLE_W : IDLE;
      SETTLE_W: state_nx = abort ? FINISH : settle_end ? CAPTURE : SETTLE_W;
      CAPTURE:  state_nx = abort ? FINISH : SEND;
      SEND:     state_nx = abort ? FINISH : !hs ? SEND : last_byte ? FINISH : SETTLE_W;
      FINISH:   state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr      <= IDLE_ADDR;
      cnt       <= 4'd0;
      out_data  <= 8'd0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          addr    <= 5'd0;
          cnt     <= 4'd0;
          aborted <= 1'b0;
        end
        SETTLE_W: cnt <= settle_end ? 4'd0 : cnt + 4'd1;
        CAPTURE: if (!abort) begin
          out_data  <= rd_data;
          out_valid <= 1'b1;
          out_first <= addr == 5'd0;
          out_last  <= last_byte;
        end
        SEND: if (hs || abort) begin
          out_valid <= 1'b0;
          out_first <= 1'b0;
          out_last  <= 1'b0;
          // an accepted byte still advances only if the frame continues
          if (hs && !abort && !last_byte) addr <= addr + 5'd1;
        end
        FINISH: addr <= IDLE_ADDR;
        default: addr <= IDLE_ADDR;
      endcase
      if (abort && in_frame) aborted <= 1'b1;
    end
endmodule

// File: tb/tb_readout_seq.sv
// tb_readout_seq: directed checks of readout_seq at SETTLE=2, 1 and 15.
module tb_readout_seq;
  localparam int NB = 24;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       abort = 1'b0;
  logic       out_ready = 1'b1;
  logic       st[3];
  logic [4:0] addr_w[3];
  logic [7:0] rd[3], od[3];
  logic       ov[3], of[3], ol[3], bz[3], dn[3], ab[3];
  int         total = 0, passed = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_rd
    assign rd[g] = 8'h40 + {3'd0, addr_w[g]};
  end
  readout_seq #(.NUM_BYTES(NB), .SETTLE(2)) u0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .abort(abort), .addr(addr_w[0]),
    .rd_data(rd[0]), .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .out_first(of[0]), .out_last(ol[0]), .busy(bz[0]), .done(dn[0]), .aborted(ab[0]));
  readout_seq #(.NUM_BYTES(NB), .SETTLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .abort(abort), .addr(addr_w[1]),
    .rd_data(rd[1]), .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .out_first(of[1]), .out_last(ol[1]), .busy(bz[1]), .done(dn[1]), .aborted(ab[1]));
  readout_seq #(.NUM_BYTES(NB), .SETTLE(15)) u2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .abort(abort), .addr(addr_w[2]),
    .rd_data(rd[2]), .out_data(od[2]), .out_valid(ov[2]), .out_ready(out_ready),
    .out_first(of[2]), .out_last(ol[2]), .busy(bz[2]), .done(dn[2]), .aborted(ab[2]));
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  // Runs one frame on instance k; optionally holds out_ready low for sl cycles
  // while byte sb is offered. Latency and period are in clock edges.
  task automatic run_frame(input int k, input int sb, input int sl, output int nb,
                           output int er, output int lat, output int per, output int nd);
    int c0, c1, sc;
    bit fin;
    nb = 0; er = 0; lat = 0; nd = 0; sc = 0; c0 = 0; c1 = 0; fin = 0;
    out_ready = 1'b1;
    st[k] = 1'b1;
    for (int c = 1; c <= 2000 && !fin; c++) begin
      @(posedge clk); #1;
      st[k] = 1'b0;
      if (dn[k]) nd++;
      if (ov[k] && lat == 0) lat = c;
      if (ov[k] && nb == sb && sc < sl) begin
        out_ready = 1'b0;
        sc++;
        if (od[k] != 8'(8'h40 + sb) || addr_w[k] != 5'(sb)) er++;
      end else begin
        out_ready = 1'b1;
        if (!ov[k] && nb == sb && sc > 0 && sc < sl) er++;
      end
      if (ov[k] && out_ready) begin
        if (od[k] != 8'(8'h40 + nb) || of[k] != (nb == 0) || ol[k] != (nb == NB - 1)) er++;
        if (nb == 0) c0 = c;
        if (nb == 1) c1 = c;
        nb++;
      end
      if (!bz[k] && c > 1) fin = 1;
      if (c == 2000 && !fin) er++;
    end
    per = c1 - c0;
  endtask
  task automatic wait_addr(input logic [4:0] a);
    bit hit = 0;
    for (int c = 0; c < 500 && !hit; c++) begin
      @(posedge clk); #1;
      st[0] = 1'b0;
      hit = addr_w[0] == a;
    end
    chk("wait_addr_reached", int'(hit), 1);
  endtask
  typedef struct {
    int k;
    int sb;
    int sl;
    int exp_lat;
    int exp_per;
  } vec_t;
  initial begin
    vec_t tbl[5];
    int nb, er, lat, per, nd, nrise, gap, nv;
    logic pv;
    tbl[0] = '{0, -1, 0, 4, 4};
    tbl[1] = '{0, 3, 5, 4, 4};
    tbl[2] = '{1, -1, 0, 3, 3};
    tbl[3] = '{2, -1, 0, 17, 17};
    tbl[4] = '{2, 5, 2, 17, 17};
    for (int i = 0; i < 3; i++) st[i] = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_addr", int'(addr_w[0]), 31);
    chk("rst_valid", int'(ov[0]), 0);
    chk("rst_busy", int'(bz[0]), 0);
    chk("rst_done", int'(dn[0]), 0);
    chk("rst_aborted", int'(ab[0]), 0);
    chk("rst_data", int'(od[0]), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("idle_abort_busy", int'(bz[0]), 0);
    chk("idle_abort_aborted", int'(ab[0]), 0);
    for (int i = 0; i < 5; i++) begin
      run_frame(tbl[i].k, tbl[i].sb, tbl[i].sl, nb, er, lat, per, nd);
      chk($sformatf("row%0d_nbytes", i), nb, NB);
      chk($sformatf("row%0d_byte_errs", i), er, 0);
      chk($sformatf("row%0d_done_pulses", i), nd, 1);
      chk($sformatf("row%0d_latency", i), lat, tbl[i].exp_lat);
      chk($sformatf("row%0d_period", i), per, tbl[i].exp_per);
      chk($sformatf("row%0d_addr_after", i), int'(addr_w[tbl[i].k]), 31);
      chk($sformatf("row%0d_aborted", i), int'(ab[tbl[i].k]), 0);
    end
    out_ready = 1'b1;
    st[0] = 1'b1;
    wait_addr(5'd10);
    chk("abort_pre_busy", int'(bz[0]), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_done", int'(dn[0]), 1);
    chk("abort_aborted", int'(ab[0]), 1);
    chk("abort_valid", int'(ov[0]), 0);
    chk("abort_busy_finish", int'(bz[0]), 1);
    @(posedge clk); #1;
    chk("abort_busy_low", int'(bz[0]), 0);
    chk("abort_done_once", int'(dn[0]), 0);
    chk("abort_aborted_held", int'(ab[0]), 1);
    chk("abort_addr", int'(addr_w[0]), 31);
    nv = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ov[0]) nv++;
    end
    chk("abort_no_valid", nv, 0);
    run_frame(0, -1, 0, nb, er, lat, per, nd);
    chk("post_abort_nbytes", nb, NB);
    chk("post_abort_errs", er, 0);
    chk("post_abort_aborted", int'(ab[0]), 0);
    nrise = 0; gap = 0; nb = 0; nd = 0; pv = 1'b0;
    out_ready = 1'b0;
    st[0] = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      st[0] = c < 100;
      out_ready = c >= 20;
      if (ov[0] && out_ready) nb++;
      if (dn[0]) nd++;
      if (bz[0] && !pv) nrise++;
      if (!bz[0] && nd == 0) gap++;
      pv = bz[0];
      if (nd > 0 && !bz[0]) break;
    end
    st[0] = 1'b0;
    chk("spam_frames", nrise, 1);
    chk("spam_busy_gap", gap, 0);
    chk("spam_done", nd, 1);
    chk("spam_nbytes", nb, NB);
    repeat (5) @(posedge clk);
    #1;
    chk("spam_idle_after", int'(bz[0]), 0);
    st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    chk("spam_restart", int'(bz[0]), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(posedge clk); #1;
    chk("spam_cleanup", int'(bz[0]), 0);
    out_ready = 1'b1;
    st[0] = 1'b1;
    wait_addr(5'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_addr", int'(addr_w[0]), 31);
    chk("midrst_valid", int'(ov[0]), 0);
    chk("midrst_data", int'(od[0]), 0);
    chk("midrst_busy", int'(bz[0]), 0);
    chk("midrst_first", int'(of[0]), 0);
    nd = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (dn[0]) nd++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (dn[0]) nd++;
    end
    chk("midrst_no_done", nd, 0);
    run_frame(0, -1, 0, nb, er, lat, per, nd);
    chk("midrst_nbytes", nb, NB);
    chk("midrst_errs", er, 0);
    chk("midrst_latency", lat, 4);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
